// File: rtl/voxel_feature_streamer.sv
// rtl/voxel_feature_streamer.sv - voxel bin RAM to systolic classifier feature streamer (optional STREAMER_CLEAR_ON_READ_EN)
module voxel_feature_streamer #(
  parameter int NUM_CELLS       = 1024,
  parameter int PARALLEL_INPUTS = 4,
  parameter int COUNT_BITS      = 8,
  parameter int VALUE_BITS      = 6,
  localparam int AW             = $clog2(NUM_CELLS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  frame_ready,
  output logic [PARALLEL_INPUTS*AW-1:0]         rd_addr_flat,
  input  logic [PARALLEL_INPUTS*COUNT_BITS-1:0] rd_data_flat,
  output logic                                  frame_consumed,
  output logic                                  cls_start,
  output logic [PARALLEL_INPUTS*VALUE_BITS-1:0] feature_in,
  output logic                                  feature_valid,
  input  logic                                  cls_result_valid,
  input  logic [1:0]                            cls_best_class,
  output logic                                  gesture_valid,
  output logic [1:0]                            gesture_class,
  output logic                                  busy,
  output logic [7:0]                            overrun_cnt
`ifdef STREAMER_CLEAR_ON_READ_EN
  ,
  output logic                                  wr_en,
  output logic [PARALLEL_INPUTS*AW-1:0]         wr_addr_flat,
  output logic [PARALLEL_INPUTS*COUNT_BITS-1:0] wr_data_flat
`endif
);

  localparam int BEATS = (NUM_CELLS + PARALLEL_INPUTS - 1) / PARALLEL_INPUTS;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MAXV  = (1 << VALUE_BITS) - 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH, S_WAIT} state_t;

  state_t                 state, state_n;
  logic [BW-1:0]          beat_cnt, beat_n;
  logic                   flush_cnt, flush_n;
  logic                   issue;
  logic                   accept_result;
  logic [PARALLEL_INPUTS-1:0] lane_ok;
  logic [PARALLEL_INPUTS-1:0] rd_mask;
  logic                   rd_pending;
  int                     cell_idx;

  // Clamp a raw bin count to the largest feature value the classifier accepts.
  function automatic logic [VALUE_BITS-1:0] sat(input logic [COUNT_BITS-1:0] c);
    if (int'(c) > MAXV) sat = VALUE_BITS'(MAXV);
    else                sat = VALUE_BITS'(c);
  endfunction

  assign issue         = (state == S_ISSUE);
  assign busy          = (state != S_IDLE);
  assign accept_result = (state == S_WAIT) && cls_result_valid;

  // State, beat and flush counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_n;
      beat_cnt  <= beat_n;
      flush_cnt <= flush_n;
    end
  end

  // Next-state logic plus the start and bank-release pulses.
  always_comb begin
    state_n        = state;
    beat_n         = beat_cnt;
    flush_n        = flush_cnt;
    cls_start      = 1'b0;
    frame_consumed = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (frame_ready) begin
          state_n = S_ISSUE;
          beat_n  = '0;
        end
      end
      S_ISSUE: begin
        cls_start = (beat_cnt == '0);
        if (beat_cnt == LAST_BEAT) begin
          state_n = S_FLUSH;
          flush_n = 1'b0;
        end else begin
          beat_n = beat_cnt + BW'(1);
        end
      end
      S_FLUSH: begin
        // First flush cycle directly follows the last address issue.
        frame_consumed = (flush_cnt == 1'b0);
        if (flush_cnt) state_n = S_WAIT;
        else           flush_n = 1'b1;
      end
      S_WAIT: begin
        if (cls_result_valid) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Lane addresses for the current beat; lanes past the last cell read address 0.
  always_comb begin
    rd_addr_flat = '0;
    lane_ok      = '0;
    cell_idx     = 0;
    for (int p = 0; p < PARALLEL_INPUTS; p++) begin
      cell_idx = int'(beat_cnt) * PARALLEL_INPUTS + p;
      if (issue && (cell_idx < NUM_CELLS)) begin
        lane_ok[p]                   = 1'b1;
        rd_addr_flat[p*AW +: AW]     = cell_idx[AW-1:0];
      end
    end
  end

  // Two-stage read pipe: RAM latency, then registered saturation onto the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending    <= 1'b0;
      rd_mask       <= '0;
      feature_valid <= 1'b0;
      feature_in    <= '0;
    end else begin
      rd_pending    <= issue;
      rd_mask       <= lane_ok;
      feature_valid <= rd_pending;
      for (int p = 0; p < PARALLEL_INPUTS; p++) begin
        if (rd_pending && rd_mask[p])
          feature_in[p*VALUE_BITS +: VALUE_BITS] <= sat(rd_data_flat[p*COUNT_BITS +: COUNT_BITS]);
        else
          feature_in[p*VALUE_BITS +: VALUE_BITS] <= '0;
      end
    end
  end

  // Gesture republishing and dropped-frame accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      gesture_valid <= 1'b0;
      gesture_class <= 2'd0;
      overrun_cnt   <= 8'd0;
    end else begin
      gesture_valid <= accept_result;
      if (accept_result) gesture_class <= cls_best_class;
      if (frame_ready && busy && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

`ifdef STREAMER_CLEAR_ON_READ_EN
  // Clear each cell one cycle after it is read; out-of-range lanes rewrite cell 0 with 0,
  // which beat 0 clears anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en        <= 1'b0;
      wr_addr_flat <= '0;
    end else begin
      wr_en        <= issue;
      wr_addr_flat <= rd_addr_flat;
    end
  end

  assign wr_data_flat = '0;
`endif

endmodule

// File: tb/tb_voxel_feature_streamer.sv
// tb/tb_voxel_feature_streamer.sv - scoreboard bench for voxel_feature_streamer (16-cell and 10-cell builds)
module tb_voxel_feature_streamer;

  localparam int P  = 4;
  localparam int CB = 8;
  localparam int VB = 6;
  localparam int AW = 4;

  typedef struct {
    int          cyc;
    logic [23:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Cycle index: the period after posedge N is cycle N.
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: 16 cells
  logic              fr_a = 1'b0, rv_a = 1'b0;
  logic [1:0]        bc_a = 2'd0;
  logic [P*AW-1:0]   addr_a;
  logic [P*CB-1:0]   data_a;
  logic              cons_a, start_a, fv_a, gv_a, busy_a;
  logic [P*VB-1:0]   feat_a;
  logic [1:0]        gc_a;
  logic [7:0]        ovr_a;
  // DUT B: 10 cells, partial last beat
  logic              fr_b = 1'b0, rv_b = 1'b0;
  logic [1:0]        bc_b = 2'd0;
  logic [P*AW-1:0]   addr_b;
  logic [P*CB-1:0]   data_b;
  logic              cons_b, start_b, fv_b, gv_b, busy_b;
  logic [P*VB-1:0]   feat_b;
  logic [1:0]        gc_b;
  logic [7:0]        ovr_b;
`ifdef STREAMER_CLEAR_ON_READ_EN
  logic              wen_a, wen_b;
  logic [P*AW-1:0]   waddr_a, waddr_b;
  logic [P*CB-1:0]   wdata_a, wdata_b;
`endif

  voxel_feature_streamer #(.NUM_CELLS(16), .PARALLEL_INPUTS(P), .COUNT_BITS(CB), .VALUE_BITS(VB)) dut_a (
    .clk(clk), .rst(rst), .frame_ready(fr_a), .rd_addr_flat(addr_a), .rd_data_flat(data_a),
    .frame_consumed(cons_a), .cls_start(start_a), .feature_in(feat_a), .feature_valid(fv_a),
    .cls_result_valid(rv_a), .cls_best_class(bc_a), .gesture_valid(gv_a), .gesture_class(gc_a),
    .busy(busy_a), .overrun_cnt(ovr_a)
`ifdef STREAMER_CLEAR_ON_READ_EN
    , .wr_en(wen_a), .wr_addr_flat(waddr_a), .wr_data_flat(wdata_a)
`endif
  );

  voxel_feature_streamer #(.NUM_CELLS(10), .PARALLEL_INPUTS(P), .COUNT_BITS(CB), .VALUE_BITS(VB)) dut_b (
    .clk(clk), .rst(rst), .frame_ready(fr_b), .rd_addr_flat(addr_b), .rd_data_flat(data_b),
    .frame_consumed(cons_b), .cls_start(start_b), .feature_in(feat_b), .feature_valid(fv_b),
    .cls_result_valid(rv_b), .cls_best_class(bc_b), .gesture_valid(gv_b), .gesture_class(gc_b),
    .busy(busy_b), .overrun_cnt(ovr_b)
`ifdef STREAMER_CLEAR_ON_READ_EN
    , .wr_en(wen_b), .wr_addr_flat(waddr_b), .wr_data_flat(wdata_b)
`endif
  );

  // RAM models: one-cycle read latency, bench load port, optional DUT clear port
  logic [7:0] ram_a [16];
  logic [7:0] ram_b [16];
  logic       ld_sel = 1'b0, ld_en = 1'b0;
  logic [3:0] ld_addr = 4'd0;
  logic [7:0] ld_data = 8'd0;

  always @(posedge clk) begin
    if (ld_en && !ld_sel) ram_a[ld_addr] <= ld_data;
`ifdef STREAMER_CLEAR_ON_READ_EN
    if (wen_a) for (int p = 0; p < P; p++) ram_a[waddr_a[p*AW +: AW]] <= wdata_a[p*CB +: CB];
`endif
    for (int p = 0; p < P; p++) data_a[p*CB +: CB] <= ram_a[addr_a[p*AW +: AW]];
  end

  always @(posedge clk) begin
    if (ld_en && ld_sel) ram_b[ld_addr] <= ld_data;
`ifdef STREAMER_CLEAR_ON_READ_EN
    if (wen_b) for (int p = 0; p < P; p++) ram_b[waddr_b[p*AW +: AW]] <= wdata_b[p*CB +: CB];
`endif
    for (int p = 0; p < P; p++) data_b[p*CB +: CB] <= ram_b[addr_b[p*AW +: AW]];
  end

  beat_t exp_a[$];
  beat_t exp_b[$];
  int    exp_g[$];

  function automatic logic [23:0] b4(input int v3, input int v2, input int v1, input int v0);
    b4 = {6'(v3), 6'(v2), 6'(v1), 6'(v0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic load_ram(input logic sel, input int vals[16]);
    ld_sel = sel;
    for (int i = 0; i < 16; i++) begin
      ld_en   = 1'b1;
      ld_addr = 4'(i);
      ld_data = 8'(vals[i]);
      step();
    end
    ld_en = 1'b0;
  endtask

  task automatic push_a(input int t0, input int b, input logic [23:0] d);
    beat_t e;
    e.cyc  = t0 + 3 + b;
    e.data = d;
    exp_a.push_back(e);
  endtask

  task automatic push_basic_a(input int t0);
    push_a(t0, 0, b4(3, 2, 1, 0));
    push_a(t0, 1, b4(7, 6, 5, 4));
    push_a(t0, 2, b4(11, 10, 9, 8));
    push_a(t0, 3, b4(15, 14, 13, 12));
  endtask

  task automatic start_a_frame(output int t0);
    fr_a = 1'b1;
    t0   = cyc;
    step();
    fr_a = 1'b0;
  endtask

  task automatic result_a(input logic [1:0] c);
    rv_a = 1'b1;
    bc_a = c;
    exp_g.push_back(int'(c));
    step();
    rv_a = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a beat or gesture is presented
  always @(negedge clk) begin
    beat_t e;
    if (fv_a) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL beat_a unexpected: got %0h at cycle %0d", feat_a, cyc);
      end else begin
        e = exp_a.pop_front();
        if (feat_a !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL beat_a: got %0h at cycle %0d expected %0h at cycle %0d", feat_a, cyc, e.data, e.cyc);
        end
      end
    end else if (feat_a !== 24'd0 && !$isunknown(fv_a)) begin
      checks++;
      errors++;
      $display("FAIL feat_a idle: got %0h expected 0 (cycle %0d)", feat_a, cyc);
    end
    if (fv_b) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL beat_b unexpected: got %0h at cycle %0d", feat_b, cyc);
      end else begin
        e = exp_b.pop_front();
        if (feat_b !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL beat_b: got %0h at cycle %0d expected %0h at cycle %0d", feat_b, cyc, e.data, e.cyc);
        end
      end
    end
    if (gv_a) begin
      checks++;
      if (exp_g.size() == 0) begin
        errors++;
        $display("FAIL gesture unexpected: got class %0d at cycle %0d", gc_a, cyc);
      end else if (int'(gc_a) != exp_g[0]) begin
        errors++;
        $display("FAIL gesture class: got %0d expected %0d", gc_a, exp_g[0]);
        void'(exp_g.pop_front());
      end else begin
        void'(exp_g.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int basic[16];
    int satv[16];
    int partial[16];
    for (int i = 0; i < 16; i++) begin
      basic[i]   = i;
      satv[i]    = i;
      partial[i] = (i < 10) ? i * 8 : 99;
    end
    satv[0] = 200; satv[1] = 63; satv[2] = 64; satv[3] = 5;
    partial[0] = 40;

    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst busy", busy_a, 0);
    chk("rst cls_start", start_a, 0);
    chk("rst addr", addr_a, 0);
    chk("rst feat", {fv_a, feat_a}, 0);
    chk("rst gesture", {gv_a, gc_a}, 0);
    chk("rst overrun", ovr_a, 0);
    chk("rst consumed", cons_a, 0);

    // Basic stream, timing and addresses
    load_ram(1'b0, basic);
    start_a_frame(t0);
    push_basic_a(t0);
    chk("basic cls_start c1", start_a, 1);
    chk("basic busy c1", busy_a, 1);
    chk("basic addr beat0", addr_a, 16'h3210);
    step();
    chk("basic cls_start c2", start_a, 0);
    chk("basic addr beat1", addr_a, 16'h7654);
    wait_to(t0 + 4);
    chk("basic addr beat3", addr_a, 16'hFEDC);
    chk("basic consumed c4", cons_a, 0);
    step();
    chk("basic consumed c5", cons_a, 1);
    chk("basic addr flush", addr_a, 0);
    step();
    chk("basic consumed c6", cons_a, 0);

    // Overrun while waiting for the classifier
    wait_to(t0 + 10);
    repeat (3) begin
      fr_a = 1'b1; step(); fr_a = 1'b0; step();
    end
    chk("overrun 3", ovr_a, 3);
    chk("busy in wait", busy_a, 1);

    // Result path
    result_a(2'd2);
    chk("result busy drop", busy_a, 0);
    chk("result class", gc_a, 2);
    step();
    rv_a = 1'b1; bc_a = 2'd1; step(); rv_a = 1'b0;
    chk("idle result no gv", gv_a, 0);
    chk("idle result class held", gc_a, 2);
    chk("idle result stays idle", busy_a, 0);
    step();

    // Saturation
    load_ram(1'b0, satv);
    start_a_frame(t0);
    push_a(t0, 0, b4(5, 63, 63, 63));
    push_a(t0, 1, b4(7, 6, 5, 4));
    push_a(t0, 2, b4(11, 10, 9, 8));
    push_a(t0, 3, b4(15, 14, 13, 12));
    wait_to(t0 + 9);
    result_a(2'd1);
    step();

    // Overrun saturation: 300 dropped cycles on top of the earlier 3
    load_ram(1'b0, basic);
    start_a_frame(t0);
    push_basic_a(t0);
    fr_a = 1'b1;
    repeat (300) step();
    fr_a = 1'b0;
    chk("overrun saturate", ovr_a, 255);
    result_a(2'd3);
    step();

    // Reset during the third beat
    load_ram(1'b0, basic);
    start_a_frame(t0);
    push_a(t0, 0, b4(3, 2, 1, 0));
    push_a(t0, 1, b4(7, 6, 5, 4));
    push_a(t0, 2, b4(11, 10, 9, 8));
    wait_to(t0 + 5);
    rst = 1'b1;
    step();
    chk("midrst feat", {fv_a, feat_a}, 0);
    chk("midrst busy", busy_a, 0);
    chk("midrst overrun", ovr_a, 0);
    chk("midrst gesture", {gv_a, gc_a}, 0);
    chk("midrst addr", {start_a, cons_a, addr_a}, 0);
    rst = 1'b0;
    repeat (12) begin
      step();
      chk("post-rst quiet", {start_a, fv_a, busy_a}, 0);
    end

    // Full frame, then a second frame without reloading the RAM
    load_ram(1'b0, basic);
    start_a_frame(t0);
    push_basic_a(t0);
    wait_to(t0 + 9);
    result_a(2'd0);
    step();
    start_a_frame(t0);
`ifdef STREAMER_CLEAR_ON_READ_EN
    for (int b = 0; b < 4; b++) push_a(t0, b, 24'd0);
`else
    push_basic_a(t0);
`endif
    wait_to(t0 + 9);
    result_a(2'd2);
    step();

    // Partial last beat on the 10-cell build
    load_ram(1'b1, partial);
    fr_b = 1'b1;
    t0   = cyc;
    step();
    fr_b = 1'b0;
    exp_b.push_back('{t0 + 3, b4(24, 16, 8, 40)});
    exp_b.push_back('{t0 + 4, b4(56, 48, 40, 32)});
    exp_b.push_back('{t0 + 5, b4(0, 0, 63, 63)});
    chk("partial cls_start", start_b, 1);
    chk("partial addr beat0", addr_b, 16'h3210);
    wait_to(t0 + 3);
    chk("partial addr beat2", addr_b, 16'h0098);
    step();
    chk("partial consumed", cons_b, 1);
    wait_to(t0 + 8);
    chk("partial busy in wait", busy_b, 1);
    rv_b = 1'b1; bc_b = 2'd3; step(); rv_b = 1'b0;
    chk("partial gesture", {gv_b, gc_b, busy_b}, {1'b1, 2'd3, 1'b0});
    repeat (4) step();

    chk("scoreboard a drained", exp_a.size(), 0);
    chk("scoreboard b drained", exp_b.size(), 0);
    chk("gesture drained", exp_g.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/voxel_feature_streamer.md
Name: voxel_feature_streamer

Overview:
- Producer side of the classifier's feature interface.
- On a frame-ready pulse from the voxel binning stage, reads NUM_CELLS bin counts from the voxel RAM, PARALLEL_INPUTS cells per cycle, and saturates each count to VALUE_BITS.
- Issues a start pulse and streams packed beats into the systolic classifier, then waits for the classifier's result and republishes it as a gesture event.
- Sits between the voxel bin memory and systolic_array-style classifiers.

Parameters:
NUM_CELLS, 1024, voxel cells per frame
PARALLEL_INPUTS, 4, cells per beat (power of two)
COUNT_BITS, 8, width of a raw bin count in RAM
VALUE_BITS, 6, width of a feature value sent to classifier (unsigned)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
frame_ready  in  1  pulse: voxel frame complete, RAM stable
rd_addr_flat  out  PARALLEL_INPUTS*$clog2(NUM_CELLS)  RAM read addresses, lane p at [p*AW +: AW]
rd_data_flat  in  PARALLEL_INPUTS*COUNT_BITS  RAM read data, valid 1 cycle after address
frame_consumed  out  1  pulse: final RAM read issued, binning may reuse bank
cls_start  out  1  pulse to classifier start
feature_in  out  PARALLEL_INPUTS*VALUE_BITS  packed beat, lane p at [p*VALUE_BITS +: VALUE_BITS]
feature_valid  out  1  beat valid
cls_result_valid  in  1  classifier result pulse
cls_best_class  in  2  classifier argmax
gesture_valid  out  1  pulse: new gesture result
gesture_class  out  2  held last result
busy  out  1  high outside S_IDLE
overrun_cnt  out  8  saturating count of dropped frame_ready pulses

Behaviour:
- BEATS = ceil(NUM_CELLS/PARALLEL_INPUTS); AW = $clog2(NUM_CELLS).
- Reset values: all outputs 0, state S_IDLE. Reset mid-operation aborts immediately; no further cls_start or feature_valid until the next frame_ready.
- States:
  - S_IDLE: on frame_ready go to S_ISSUE.
  - S_ISSUE: drives cls_start (first cycle only) and read addresses, one beat per cycle. After beat BEATS-1 is issued go to S_FLUSH.
  - S_FLUSH: waits for the last beat to leave the pipe (2 cycles), then goes to S_WAIT.
  - S_WAIT: on cls_result_valid go to S_IDLE.
- Timing, with frame_ready sampled at cycle 0:
  - Cycle 1: cls_start=1 for exactly one cycle; rd_addr_flat holds beat 0.
  - Cycle 1+b: rd_addr_flat holds beat b, lane p address = b*PARALLEL_INPUTS+p.
  - Cycle 3+b: feature_valid=1 with beat b.
  - Beats are back-to-back with no gaps; feature_valid is high for exactly BEATS consecutive cycles.
- Lanes with index b*PARALLEL_INPUTS+p >= NUM_CELLS: address 0, feature value 0.
- Saturation is registered: value = min(count, 2^VALUE_BITS-1), unsigned.
- frame_consumed: one-cycle pulse in the cycle after the last address is issued (cycle 1+BEATS).
- S_WAIT: on cls_result_valid, gesture_class <= cls_best_class and gesture_valid pulses in the next cycle. cls_result_valid outside S_WAIT is ignored.
- frame_ready while busy is dropped and increments overrun_cnt, which saturates at 255. frame_ready in the same cycle S_WAIT returns to S_IDLE also counts as dropped.
- feature_in is held at 0 when feature_valid is 0.

Optional Feature:
- Macro STREAMER_CLEAR_ON_READ_EN.
- When defined, adds ports wr_en (1), wr_addr_flat (PARALLEL_INPUTS*AW) and wr_data_flat (PARALLEL_INPUTS*COUNT_BITS).
  - Each in-range cell read in cycle t is written with 0 in cycle t+1 (wr_en=1, same addresses).
  - Out-of-range lanes write address 0 only if cell 0 is already being cleared in that beat; otherwise the lane is masked by writing the cell's own value. Simplest compliant form: lane write of 0 to address 0, which is always cleared in beat 0.
- When undefined, there are no write ports and RAM contents are untouched.

Test Plan:
- Basic stream (NUM_CELLS=16, P=4): RAM cell i = i, frame_ready at cycle 0 -> cls_start at cycle 1; feature_valid cycles 3..6; beat 0 = {3,2,1,0}, beat 3 = {15,14,13,12}; frame_consumed at cycle 5.
- Saturation: cell 0=200, cell 1=63, cell 2=64 -> lanes read 63, 63, 63.
- Partial last beat (NUM_CELLS=10, P=4): 3 beats; beat 2 lanes 2..3 = 0 with address 0.
- Result path: cls_result_valid with cls_best_class=2 in S_WAIT -> gesture_valid one cycle later, gesture_class=2, busy drops; a second result pulse in S_IDLE -> no gesture_valid.
- Overrun: 3 frame_ready pulses while busy -> overrun_cnt=3; 300 pulses -> 255.
- Reset at the third feature_valid cycle -> all outputs 0 next cycle and no beats until a new frame_ready; with STREAMER_CLEAR_ON_READ_EN, all 16 cells read 0 after a completed frame.
